// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg: shared constants, state encoding and bit-reverse helper     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fft_pkg;

   localparam int WORDSIZE   = 16;
   localparam int NUMSTAGES  = 5;
   localparam int NUMSAMPLES = 32;
   localparam int NUMBANKS   = 4;
   localparam int BANKADDR   = NUMSTAGES - 2;
   localparam int WL         = 16;
   localparam int IWL        = 5;
   localparam int FWL        = 10;

   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   function automatic logic [NUMSTAGES-1:0] bitrev(input logic [NUMSTAGES-1:0] n);
      logic [NUMSTAGES-1:0] r;
      r = '0;
      for (int i = 0; i < NUMSTAGES; i++) begin
         r[i] = n[NUMSTAGES-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bank_addr_map.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bank_addr_map: sample index -> {bank, row} under optional bit-reverse |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bank_addr_map
   import fft_pkg::*;
#(
   parameter int BITREV = 1
) (
   input  logic [NUMSTAGES-1:0] i_idx,
   output logic [1:0]           o_bank,
   output logic [NUMSTAGES-3:0] o_addr
);

   logic [NUMSTAGES-1:0] w_r;

   generate
      if (BITREV != 0) begin : g_bitrev
         assign w_r = bitrev(i_idx);
      end else begin : g_natural
         assign w_r = i_idx;
      end
   endgenerate

   // Low two bits interleave across banks so a row read returns 4 consecutive points.
   assign o_bank = w_r[1:0];
   assign o_addr = w_r[NUMSTAGES-1:2];

endmodule
`default_nettype wire

// File: rtl/fft_input_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_input_sequencer: fills 4 RAM banks in bit-reversed order, then   |
// | drains them one row (4 samples) per cycle. Revision: 1.0             |
// +----------------------------------------------------------------------+
module fft_input_sequencer #(
   parameter int WORDSIZE   = fft_pkg::WORDSIZE,
   parameter int NUMSTAGES  = fft_pkg::NUMSTAGES,
   parameter int NUMSAMPLES = fft_pkg::NUMSAMPLES,
   parameter int NUMBANKS   = fft_pkg::NUMBANKS,
   parameter int BANKADDR   = NUMSTAGES - 2,
   parameter int BITREV     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [WORDSIZE-1:0]          in_data,
   output logic                         in_ready,
   output logic [BANKADDR-1:0]          ram_wr_addr,
   output logic [BANKADDR-1:0]          ram_rd_addr,
   output logic [NUMBANKS-1:0]          ram_wr_en,
   output logic                         ram_rd_en,
   output logic [NUMBANKS-1:0]          ram_cs,
   output logic [WORDSIZE-1:0]          ram_data_in,
   input  logic [NUMBANKS*WORDSIZE-1:0] ram_rd_data,
   output logic                         out_valid,
   output logic [NUMBANKS*WORDSIZE-1:0] out_data,
   output logic [BANKADDR-1:0]          out_idx,
   output logic                         out_last
);

   localparam logic [NUMSTAGES-1:0] c_WLAST = NUMSTAGES'(NUMSAMPLES - 1);
   localparam logic [BANKADDR-1:0]  c_RLAST = BANKADDR'(NUMSAMPLES / NUMBANKS - 1);

   logic [0:0]           r_state;
   logic [NUMSTAGES-1:0] r_wcnt;
   logic [BANKADDR-1:0]  r_rcnt;
   logic                 r_out_valid;
   logic [BANKADDR-1:0]  r_out_idx;
   logic                 r_out_last;

   logic                 w_fill;
   logic                 w_drain;
   logic                 w_accept;
   logic [1:0]           w_bank;
   logic [BANKADDR-1:0]  w_addr;
   logic [NUMBANKS-1:0]  w_wr_en;

   bank_addr_map #(
      .BITREV (BITREV)
   ) u_map (
      .i_idx  (r_wcnt),
      .o_bank (w_bank),
      .o_addr (w_addr)
   );

   // Strobes are gated by rst_n so nothing reaches the RAMs while reset is held.
   assign w_fill   = rst_n & (r_state == fft_pkg::FILL);
   assign w_drain  = rst_n & (r_state == fft_pkg::DRAIN);
   assign w_accept = w_fill & in_valid;
   assign w_wr_en  = w_accept ? (NUMBANKS'(1) << w_bank) : '0;

   assign in_ready    = w_fill;
   assign ram_wr_en   = w_wr_en;
   assign ram_wr_addr = w_addr;
   assign ram_data_in = in_data;
   assign ram_rd_en   = w_drain;
   assign ram_rd_addr = r_rcnt;
   assign ram_cs      = w_drain ? {NUMBANKS{1'b1}} : w_wr_en;

   assign out_valid = r_out_valid;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;
   assign out_data  = ram_rd_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= fft_pkg::FILL;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         // Output flags track the one-cycle RAM read latency.
         r_out_valid <= w_drain;
         r_out_idx   <= r_rcnt;
         r_out_last  <= w_drain & (r_rcnt == c_RLAST);
         if (r_state == fft_pkg::FILL) begin
            if (w_accept) begin
               if (r_wcnt == c_WLAST) begin
                  r_wcnt  <= '0;
                  r_state <= fft_pkg::DRAIN;
               end else begin
                  r_wcnt <= r_wcnt + NUMSTAGES'(1);
               end
            end
         end else begin
            if (r_rcnt == c_RLAST) begin
               r_rcnt  <= '0;
               r_state <= fft_pkg::FILL;
            end else begin
               r_rcnt <= r_rcnt + BANKADDR'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_input_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_input_sequencer: bench with RAM model and frame-level reference|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fft_input_sequencer;

   localparam int W  = 16;
   localparam int NB = 4;
   localparam int NS = 32;
   localparam int NR = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic [2:0]    ram_wr_addr, ram_rd_addr;
   logic [NB-1:0] ram_wr_en, ram_cs;
   logic          ram_rd_en;
   logic [W-1:0]  ram_data_in;
   logic [NB*W-1:0] ram_rd_data;
   logic          out_valid;
   logic [NB*W-1:0] out_data;
   logic [2:0]    out_idx;
   logic          out_last;

   fft_input_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .ram_wr_addr (ram_wr_addr),
      .ram_rd_addr (ram_rd_addr),
      .ram_wr_en   (ram_wr_en),
      .ram_rd_en   (ram_rd_en),
      .ram_cs      (ram_cs),
      .ram_data_in (ram_data_in),
      .ram_rd_data (ram_rd_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_beats = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int brev5(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 5; i++) if (((n >> i) & 1) != 0) r += 1 << (4 - i);
      return r;
   endfunction

   // Four banks of 8 words with registered read data.
   logic [W-1:0] mem [NB][NR];
   logic [W-1:0] rd_q [NB];
   always @(posedge clk) begin
      for (int k = 0; k < NB; k++) begin
         if (ram_cs[k] && ram_wr_en[k]) mem[k][ram_wr_addr] <= ram_data_in;
         if (ram_cs[k] && ram_rd_en) rd_q[k] <= mem[k][ram_rd_addr];
      end
   end
   always_comb begin
      ram_rd_data = '0;
      for (int k = 0; k < NB; k++) ram_rd_data[k*W +: W] = rd_q[k];
   end

   // Reference: collect a frame of samples, then expect 8 rows of outputs.
   logic [W-1:0] m_frame [NS];
   logic [W-1:0] m_done  [NS];
   int m_wc = 0, m_drain_left = 0, m_out_row = 0, m_frames = 0;
   bit m_out_v = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_wc = 0;
         m_drain_left = 0;
         m_out_v = 1'b0;
      end else begin
         m_out_v   = (m_drain_left > 0);
         m_out_row = NR - m_drain_left;
         if (m_drain_left > 0) begin
            m_drain_left--;
         end else if (in_valid) begin
            m_frame[m_wc] = in_data;
            m_wc++;
            if (m_wc == NS) begin
               m_done = m_frame;
               m_wc = 0;
               m_drain_left = NR;
               m_frames++;
            end
         end
      end
   end

   always @(negedge clk) begin
      int exp_wr;
      bit exp_rd;
      #2;
      if (mon_en) begin
         exp_wr = (rst_n && m_drain_left == 0 && in_valid) ? (1 << (brev5(m_wc) % 4)) : 0;
         exp_rd = rst_n && (m_drain_left > 0);
         chk("in_ready", in_ready, rst_n && m_drain_left == 0);
         chk("wr_en", ram_wr_en, exp_wr);
         chk("cs", ram_cs, exp_rd ? 4'hF : exp_wr);
         chk("rd_en", ram_rd_en, exp_rd);
         if (exp_wr != 0) begin
            chk("wr_addr", ram_wr_addr, brev5(m_wc) / 4);
            chk("wr_data", ram_data_in, in_data);
         end
         if (exp_rd) chk("rd_addr", ram_rd_addr, NR - m_drain_left);
         chk("out_valid", out_valid, m_out_v);
         if (out_valid === 1'b1) n_beats++;
         if (m_out_v) begin
            chk("out_idx", out_idx, m_out_row);
            chk("out_last", out_last, m_out_row == NR - 1);
            for (int k = 0; k < NB; k++)
               chk("out_data", out_data[k*W +: W], m_done[brev5(m_out_row*4 + k)]);
         end
      end
   end

   task automatic drive(input bit v, input logic [W-1:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      #1;
   endtask

   typedef struct {
      int n;
      int bank;
      int addr;
   } vec_t;
   vec_t vec [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, start, guard;
      vec = '{'{0, 0, 0}, '{1, 0, 4}, '{2, 0, 2}, '{3, 0, 6}, '{4, 0, 1}, '{31, 3, 7}};

      // Reset held three cycles with valid asserted.
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h1234;
      @(posedge clk);
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h1234);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_wr_en", ram_wr_en, 0);
         chk("rst_cs", ram_cs, 0);
         chk("rst_out_valid", out_valid, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("ready_after_rst", in_ready, 1);

      // Frame 1: descending ramp, placement table checked as indices pass.
      for (int c = 0; c < NS; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 16'hFFFF - 16'(m_wc);
         #1;
         for (int t = 0; t < 6; t++) begin
            if (vec[t].n == m_wc) begin
               chk("vec_wr_en", ram_wr_en, 1 << vec[t].bank);
               chk("vec_wr_addr", ram_wr_addr, vec[t].addr);
               chk("vec_onehot", $countones(ram_wr_en), 1);
            end
         end
      end
      drive(1'b0, '0);
      chk("ready_drop", in_ready, 0);
      repeat (10) drive(1'b0, '0);
      chk("beats_f1", n_beats, 8);

      // Gapped input: valid every other cycle.
      for (cyc = 0; cyc < 100; cyc++) begin
         drive(cyc % 2 == 0, W'($urandom));
         if (!in_ready) break;
      end
      chk("gap_cycles", cyc, 63);
      repeat (10) drive(1'b0, '0);
      chk("beats_f2", n_beats, 16);

      // Random valid during fill, valid held high throughout drain.
      start = m_frames;
      guard = 0;
      while (m_frames < start + 3 && guard < 2000) begin
         @(negedge clk);
         in_valid = (m_drain_left > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         in_data  = W'($urandom);
         guard++;
      end
      chk("frames_random", m_frames - start, 3);

      // Reset partway into a frame.
      guard = 0;
      forever begin
         @(negedge clk);
         if (m_wc == 17 || guard >= 200) break;
         in_valid = 1'b1;
         in_data  = W'($urandom);
         guard++;
      end
      chk("reached_17", m_wc, 17);
      chk("beats_before_rst", n_beats, 40);
      rst_n = 1'b0;
      in_valid = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_wr_en", ram_wr_en, 0);
      @(negedge clk);
      rst_n = 1'b1;
      in_data = W'($urandom);
      #1;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_wr_en", ram_wr_en, 4'b0001);
      chk("post_rst_wr_addr", ram_wr_addr, 0);
      for (int c = 0; c < NS - 1; c++) begin
         drive(1'b1, W'($urandom));
         chk("post_rst_no_out", out_valid, 0);
      end
      repeat (12) drive(1'b0, '0);
      chk("beats_total", n_beats, 48);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_input_sequencer.md
Name: fft_input_sequencer

Overview:
- Front end of the 32-point FFT datapath; sits directly upstream of the four `ram` bank instances (WORDSIZE=16, 8 addresses each).
- Accepts a serial stream of WL=16 (IWL=5, FWL=10) samples using a valid/ready handshake.
- Writes each sample, in bit-reversed index order, into one of four RAM banks.
- Once a frame of NUMSAMPLES is stored, reads all banks in parallel and presents 4 samples per cycle to the first butterfly stage.

Parameters:
- WORDSIZE, 16, sample width in bits.
- NUMSTAGES, 5, log2(NUMSAMPLES); width of the sample index.
- NUMSAMPLES, 32, frame length.
- NUMBANKS, 4, number of RAM banks (fixed at 4).
- BANKADDR, NUMSTAGES-2, RAM address width (3).
- BITREV, 1, 1 = bit-reversed write placement; 0 = natural placement.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream sample valid
- in_data  in  WORDSIZE  upstream sample
- in_ready  out  1  block accepts a sample this cycle
- ram_wr_addr  out  BANKADDR  write address, shared by all banks
- ram_rd_addr  out  BANKADDR  read address, shared by all banks
- ram_wr_en  out  NUMBANKS  per-bank write enable
- ram_rd_en  out  1  read enable, shared by all banks
- ram_cs  out  NUMBANKS  per-bank chip select
- ram_data_in  out  WORDSIZE  write data, shared by all banks
- ram_rd_data  in  NUMBANKS*WORDSIZE  bank data_out buses concatenated; bank k at [k*WORDSIZE +: WORDSIZE]
- out_valid  out  1  out_data valid
- out_data  out  NUMBANKS*WORDSIZE  4 samples, bank-ordered
- out_idx  out  BANKADDR  RAM row currently presented
- out_last  out  1  final row of the frame

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge) returns these values:
  - state=FILL, wcnt=0, rcnt=0.
  - All ram_* enables and cs = 0; out_valid=0, out_last=0.
  - in_ready=0 while rst_n is low.
  - A reset mid-frame discards the partial frame; RAM contents are don't-care.
- FILL state:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept, with sample index n=wcnt: r = BITREV ? bitrev(n) : n; bank = r[1:0]; addr = r[NUMSTAGES-1:2].
  - Same cycle, combinational from the registered wcnt: ram_wr_en[bank]=1, ram_cs[bank]=1, ram_wr_addr=addr, ram_data_in=in_data. All other banks' wr_en/cs = 0.
  - wcnt increments on accept only; in_valid low produces no write and no count.
  - Accept with wcnt=NUMSAMPLES-1: wcnt wraps to 0, next state=DRAIN.
- DRAIN state:
  - in_ready=0; in_valid is ignored with no side effects.
  - Each cycle: ram_rd_en=1, ram_cs=4'b1111, ram_rd_addr=rcnt.
  - rcnt counts 0..NUMSAMPLES/NUMBANKS-1.
  - After issuing rcnt=7: rcnt wraps to 0, next state=FILL.
  - DRAIN lasts exactly 8 cycles.
- Read latency: RAM data_out is valid one cycle after rd_en.
  - out_valid, out_idx and out_last are registered copies of (rd_en, rcnt, rcnt==7), delayed one cycle.
  - out_data = ram_rd_data, passed through combinationally.
- Frame pipelining:
  - FILL for the next frame begins the cycle after the last read.
  - The final out_valid (out_last) therefore coincides with the first in_ready=1 cycle of the next frame.
  - This overlap is legal: the first write of the new frame is to bank 0, addr 0 and does not disturb data already read.
- No output backpressure: the consumer must accept every out_valid cycle.
- Throughput: 32 fill cycles (minimum) + 8 drain cycles per frame.
- No simultaneous read and write to the same bank ever occurs.

Decomposition:
- Shared package fft_pkg holds:
  - Constants WORDSIZE, NUMSTAGES, NUMSAMPLES, NUMBANKS, WL/IWL/FWL.
  - State encoding: FILL=1'b0, DRAIN=1'b1.
  - The bitrev function.
- One sub-module: bank_addr_map (combinational). Maps index n to {bank, addr} under BITREV. It is reusable by later stage controllers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, all ram_wr_en/cs=0, out_valid=0; the first cycle after release has in_ready=1.
- Bit-reversed placement with BITREV=1:
  - n=0 -> bank0 addr0.
  - n=1 (r=16) -> bank0 addr4.
  - n=2 (r=8) -> bank0 addr2.
  - n=3 (r=24) -> bank0 addr6.
  - n=4 (r=4) -> bank0 addr1.
  - n=31 -> bank3 addr7.
  - Check ram_wr_en one-hot each accept.
- Full frame: stream in_data=0xFFFF down to 0xFFE0 with continuous valid, against a behavioural ram model:
  - in_ready drops after the 32nd accept.
  - 8 out_valid beats, out_idx 0..7, out_last only at idx 7.
  - Each beat's data equals the expected bit-reversed samples.
- Gapped input: in_valid toggled 1/0 -> writes occur only on valid cycles; DRAIN starts after exactly 32 accepts, taking 63 cycles in total.
- in_valid held high during DRAIN -> no writes, wcnt stays 0, no samples lost.
- Reset asserted at wcnt=17 -> state FILL, wcnt=0; the next full frame drains correctly with no stale out_valid.
